serial_add_ctrl: RTL
====================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8; operand width in bits, legal range 2..32.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: reset; asynchronous, active-high.
REQ-004 Port start, input, 1: request to begin an addition.
REQ-005 Port a, input, WIDTH: operand A.
REQ-006 Port b, input, WIDTH: operand B.
REQ-007 Port cin, input, 1: carry-in to bit 0.
REQ-008 Port sum, output, WIDTH: registered result.
REQ-009 Port cout, output, 1: registered carry-out of the MSB.
REQ-010 Port busy, output, 1: high while an addition is in progress.
REQ-011 Port done, output, 1: one-cycle pulse; sum/cout valid.

Function
REQ-012 The block SHALL compute a + b + cin bit-serially, LSB first, using exactly one 1-bit full-adder cell plus a carry flip-flop.
REQ-013 FSM states SHALL be IDLE, RUN and DONE, with registered state.
REQ-014 In IDLE with start=1 at a rising edge, the block SHALL capture a, b and cin into its operand shift registers and carry flop, clear the bit counter, and enter RUN.
REQ-015 In IDLE with start=0, the block SHALL remain in IDLE and hold sum and cout.
REQ-016 Each RUN edge SHALL apply the full adder to the operand LSBs and the carry flop.
- The sum bit SHALL shift into the result register from the MSB side.
- The operand registers SHALL shift right.
- The carry flop SHALL take the cell carry-out.
- The counter SHALL increment.
REQ-017 On the RUN edge where the counter equals WIDTH-1, the final carry SHALL load into cout and the FSM SHALL enter DONE.
REQ-018 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-019 Latency: if start is sampled at edge E0, done SHALL be high in the cycle following edge E0+WIDTH; one operation occupies WIDTH+1 cycles.
REQ-020 busy SHALL equal 1 exactly when state is RUN; done SHALL equal 1 exactly when state is DONE; both SHALL be decoded from registered state.
REQ-021 start asserted in RUN or DONE SHALL be ignored; requests are not queued.
REQ-022 Changes on a, b or cin after the capture edge SHALL NOT affect the result in progress.
REQ-023 sum and cout SHALL hold their last result from DONE until the next capture edge.
REQ-024 sum and cout SHALL remain stable during RUN of the next operation; only the internal result shift register changes.
REQ-025 sum SHALL equal the low WIDTH bits of a+b+cin and cout SHALL equal bit WIDTH; no overflow flag is produced.
REQ-026 If start is held high continuously, a new operation SHALL be accepted in each IDLE cycle, giving one result every WIDTH+2 cycles.
REQ-027 The counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL never wrap during RUN.

Reset
REQ-028 While rst=1, the block SHALL asynchronously force state=IDLE, counter=0, carry flop=0, operand and result registers=0, sum=0, cout=0, busy=0, done=0.
REQ-029 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse.
REQ-030 The first start accepted after rst deasserts SHALL produce a correct result.

Verification (WIDTH=8)
REQ-031 Carry through all bits: a=8'hFF, b=8'h01, cin=0, start for 1 cycle.
- busy high for 8 cycles.
- done high in cycle 9 after the capture edge.
- sum=8'h00, cout=1.
REQ-032 Carry-in use: a=8'h5A, b=8'hA5, cin=1 -> sum=8'h00, cout=1. Then a=8'd100, b=8'd55, cin=0 -> sum=8'h9B, cout=0.
REQ-033 Busy-start rejection: start pulsed at the 3rd RUN cycle with a=8'h01, b=8'h01.
- Ignored; first result is unchanged.
- Exactly one done pulse.
- a/b toggled during RUN have no effect.
REQ-034 Reset mid-operation: rst pulsed at the 4th RUN cycle.
- Immediately: busy=0, sum=0, cout=0, no done pulse.
- Next operation: 8'h0F+8'hF0+1 -> sum=8'h00, cout=1.
REQ-035 Back-to-back: start held high with a=8'h03, b=8'h04, cin=0.
- done pulses every 10 cycles.
- sum=8'h07 and cout=0 each time.
- sum stable between pulses.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder with a small IDLE/RUN/DONE controller. Computes
//   a + b + cin one bit per clock, LSB first, with a single full-adder cell
//   and a carry flop. An operation takes WIDTH+1 cycles: WIDTH RUN cycles
//   followed by one DONE cycle.
//
//   Handshake: start is a level request sampled only in IDLE. The edge that
//   samples it captures a/b/cin. start seen in RUN or DONE is dropped, not
//   queued. done is a one-cycle pulse, and sum/cout are valid while it is
//   high. sum/cout then hold until the end of the next operation.
//
// Ports
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   start : request to begin an addition (sampled in IDLE)
//   a, b  : operands, WIDTH bits
//   cin   : carry into bit 0
//   sum   : registered result, low WIDTH bits of a+b+cin
//   cout  : registered carry out of the MSB
//   busy  : high exactly while in RUN
//   done  : high exactly while in DONE
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    // One extra counter bit so the count can reach WIDTH without wrapping.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_c;
    logic             last_bit;

    // The single full-adder cell. It works on the operand LSBs and the carry flop.
    assign fa_s     = a_sr[0] ^ b_sr[0] ^ carry;
    assign fa_c     = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (last_bit) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    // Sum bits enter at the MSB. After WIDTH shifts, bit 0 has
                    // reached the LSB position.
                    res_sr <= {fa_s, res_sr[WIDTH-1:1]};
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    carry  <= fa_c;
                    cnt    <= cnt + CW'(1);
                    // The visible result changes only here. It stays stable
                    // through the next operation's RUN phase.
                    if (last_bit) begin
                        sum  <= {fa_s, res_sr[WIDTH-1:1]};
                        cout <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
